unit_mul_cdb: RTL and testbench
===============================

// Module: unit_mul_cdb
// PURPOSE
//   Tomasulo multiply functional unit (reservation stations plus one iterative multiplier) fused with the
//   common data bus (CDB) arbiter. Accepts issued multiplies with operand tags/values and snoops the CDB for
//   pending operands. Arbitrates the multiplier's result against external ALU/DIV/LS requests and drives
//   the registered CDB that every unit and the register file snoop.
// PARAMETERS
//   NUM_RS      3         reservation stations, index 0..NUM_RS-1 (max 8)
//   MUL_CYCLES  4         cycles from multiplier start to result-ready (>=1)
//   UNIT_ID     5'b01000  upper 5 tag bits identifying this unit
// PORTS
//   clk          in   1   single clock, rising edge
//   rst          in   1   asynchronous, active-low reset
//   issue        in   1   issue one multiply this cycle
//   q1_in,q2_in  in   8   operand source tags {unit[4:0],rs[2:0]}; 0 = value valid in v*_in
//   v1_in,v2_in  in   32  operand values (used only when matching q*_in==0)
//   issue_tag    out  8   {UNIT_ID, lowest free station index} (combinational)
//   all_busy     out  1   every station occupied (combinational)
//   alu_req,div_req,ls_req     in  1   external CDB requests, held until granted
//   alu_in,div_in,ls_in        in  40  {tag[7:0],data[31:0]}
//   alu_grant,div_grant,ls_grant out 1  one-cycle pulse: request latched onto the CDB
//   cdb_request  out  1   multiplier holding a finished result
//   cdb_out      out  40  {tag,data} of the pending multiplier result
//   cdb          out  41  {valid,tag[7:0],data[31:0]}, registered
// BEHAVIOUR
//   - Reset (rst=0, asynchronous): all stations free, multiplier idle, cdb=0, cdb_request=0, cdb_out=0,
//     all grants 0.
//   - Issue, sampled on the rising edge: if issue && !all_busy, allocate the lowest-index free station.
//     That station's tag is issue_tag. Store q1/q2/v1/v2. If issue && all_busy, ignore the issue.
//   - Operand capture: a valid CDB whose tag equals a station's nonzero q stores its data into v and
//     clears q. This also applies to q*_in in the issue cycle, so the same-edge broadcast is not missed.
//   - Ready: station busy, q1==0, q2==0, not yet dispatched. While the multiplier is idle and has no
//     pending result, start the lowest-index ready station.
//   - Multiply: unsigned, result = low 32 bits of v1*v2. After MUL_CYCLES edges, cdb_request=1 and
//     cdb_out = {station tag, product}, held until granted. The multiplier does not start again before
//     the grant.
//   - Arbiter, each rising edge, fixed priority div > mul > alu > ls:
//       - Winner: cdb <= {1,tag,data}; the winner's grant pulses the same cycle.
//       - No request: cdb <= 0, valid cleared.
//   - Mul grant clears cdb_request. The station is freed when the CDB broadcasts its own tag, and can be
//     reallocated in the next cycle.
//   - Simultaneous events: issue and free on the same edge → the freed slot becomes available next cycle.
//     CDB capture takes precedence over stale v_in values.
//   - rst asserted mid-operation: all in-flight work discarded, outputs return to reset values.
// TESTING
//   1. Reset, then issue on three consecutive edges:
//        - (q1=8'h41,v2=2), then (2,3), then (4,5)
//        - → tags 8'h40, 8'h41, 8'h42; CDB broadcasts 8'h41:6, 8'h42:20, then 8'h40:12
//        - all_busy=1 after the third issue
//   2. Fourth issue while all_busy → ignored; after the first broadcast, all_busy=0 and a new issue
//      takes the freed index.
//   3. div_req and the mul result pending on the same cycle → div granted first; mul on the following
//      cycle; cdb_request held in between.
//   4. alu_req alone with alu_in={8'h08,32'd7} → next edge cdb={1,8'h08,7}, alu_grant pulse.
//      No requests → cdb valid=0.
//   5. Issue with q1 equal to the tag broadcast on that same edge → the value is captured; the multiply
//      still completes.
//   6. 32'hFFFF_FFFF*2 → 32'hFFFF_FFFE. Assert rst mid-multiply → cdb=0, all stations free, no stale
//      broadcast afterwards.

Source files
------------

// File: rtl/unit_mul_cdb_if.sv
// Issue, CDB-request and CDB-broadcast signals of the multiply unit / CDB arbiter.
// master drives issues and external requests; slave is the unit itself.
interface unit_mul_cdb_if;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PAY_W  = TAG_W + DATA_W;
    localparam int unsigned CDB_W  = PAY_W + 1;

    logic              issue;
    logic [TAG_W-1:0]  q1_in;
    logic [TAG_W-1:0]  q2_in;
    logic [DATA_W-1:0] v1_in;
    logic [DATA_W-1:0] v2_in;
    logic [TAG_W-1:0]  issue_tag;
    logic              all_busy;

    logic              alu_req;
    logic              div_req;
    logic              ls_req;
    logic [PAY_W-1:0]  alu_in;
    logic [PAY_W-1:0]  div_in;
    logic [PAY_W-1:0]  ls_in;
    logic              alu_grant;
    logic              div_grant;
    logic              ls_grant;

    logic              cdb_request;
    logic [PAY_W-1:0]  cdb_out;
    logic [CDB_W-1:0]  cdb;

    modport master (
        output issue, q1_in, q2_in, v1_in, v2_in,
               alu_req, div_req, ls_req, alu_in, div_in, ls_in,
        input  issue_tag, all_busy, alu_grant, div_grant, ls_grant,
               cdb_request, cdb_out, cdb
    );

    modport slave (
        input  issue, q1_in, q2_in, v1_in, v2_in,
               alu_req, div_req, ls_req, alu_in, div_in, ls_in,
        output issue_tag, all_busy, alu_grant, div_grant, ls_grant,
               cdb_request, cdb_out, cdb
    );
endinterface

// File: rtl/unit_mul_cdb.sv
// Tomasulo multiply unit: reservation stations, one multi-cycle multiplier and the
// fixed-priority (div > mul > alu > ls) arbiter that drives the registered CDB.
module unit_mul_cdb #(
    parameter int unsigned NUM_RS     = 3,
    parameter int unsigned MUL_CYCLES = 4,
    parameter logic [4:0]  UNIT_ID    = 5'b01000
) (
    input  logic          clk,
    input  logic          rst,
    unit_mul_cdb_if.slave bus
);
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_pay_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    logic [NUM_RS-1:0] busy_q, busy_d;
    logic [NUM_RS-1:0] disp_q, disp_d;
    logic [NUM_RS-1:0] ready;
    logic [TAG_W-1:0]  q1_q [NUM_RS];
    logic [TAG_W-1:0]  q1_d [NUM_RS];
    logic [TAG_W-1:0]  q2_q [NUM_RS];
    logic [TAG_W-1:0]  q2_d [NUM_RS];
    logic [DATA_W-1:0] v1_q [NUM_RS];
    logic [DATA_W-1:0] v1_d [NUM_RS];
    logic [DATA_W-1:0] v2_q [NUM_RS];
    logic [DATA_W-1:0] v2_d [NUM_RS];

    mul_state_e        mst_q, mst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [IDX_W-1:0]  midx_q, midx_d;
    cdb_pay_t          res_q, res_d;

    logic              cdb_vld_q, cdb_vld_d;
    cdb_pay_t          cdb_pay_q, cdb_pay_d;

    logic              free_found, rdy_found;
    logic [IDX_W-1:0]  free_idx, rdy_idx;
    logic              issue_go, start_go;
    logic              mul_req;
    logic              div_win, mul_win, alu_win, ls_win;
    logic [DATA_W-1:0] product;

    // A station is ready once both operands are resolved and it has not been sent to the multiplier.
    always_comb begin
        for (int i = 0; i < int'(NUM_RS); i++) begin
            ready[i] = busy_q[i] && !disp_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
        end
    end

    // Lowest-index free station for allocation and lowest-index ready station for dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready[i] && !rdy_found) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_go = bus.issue && free_found;
    assign start_go = (mst_q == MUL_IDLE) && rdy_found;
    assign mul_req  = (mst_q == MUL_DONE);
    assign product  = opa_q * opb_q;

    assign div_win  = bus.div_req;
    assign mul_win  = !bus.div_req && mul_req;
    assign alu_win  = !bus.div_req && !mul_req && bus.alu_req;
    assign ls_win   = !bus.div_req && !mul_req && !bus.alu_req && bus.ls_req;

    // Next-state for stations, multiplier FSM and CDB register.
    always_comb begin
        busy_d    = busy_q;
        disp_d    = disp_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        mst_d     = mst_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        midx_d    = midx_q;
        res_d     = res_q;
        cdb_vld_d = 1'b0;
        cdb_pay_d = '0;

        for (int i = 0; i < int'(NUM_RS); i++) begin
            if (cdb_vld_q && busy_q[i]) begin
                if ((q1_q[i] != '0) && (q1_q[i] == cdb_pay_q.tag)) begin
                    q1_d[i] = '0;
                    v1_d[i] = cdb_pay_q.data;
                end
                if ((q2_q[i] != '0) && (q2_q[i] == cdb_pay_q.tag)) begin
                    q2_d[i] = '0;
                    v2_d[i] = cdb_pay_q.data;
                end
                if (cdb_pay_q.tag == {UNIT_ID, IDX_W'(i)}) begin
                    busy_d[i] = 1'b0;
                    disp_d[i] = 1'b0;
                end
            end

            // An operand broadcast on the issue edge wins over the stale value presented with the issue.
            if (issue_go && (free_idx == IDX_W'(i))) begin
                busy_d[i] = 1'b1;
                disp_d[i] = 1'b0;
                q1_d[i]   = bus.q1_in;
                v1_d[i]   = bus.v1_in;
                q2_d[i]   = bus.q2_in;
                v2_d[i]   = bus.v2_in;
                if (cdb_vld_q && (bus.q1_in != '0) && (bus.q1_in == cdb_pay_q.tag)) begin
                    q1_d[i] = '0;
                    v1_d[i] = cdb_pay_q.data;
                end
                if (cdb_vld_q && (bus.q2_in != '0) && (bus.q2_in == cdb_pay_q.tag)) begin
                    q2_d[i] = '0;
                    v2_d[i] = cdb_pay_q.data;
                end
            end

            if (start_go && (rdy_idx == IDX_W'(i))) begin
                disp_d[i] = 1'b1;
                opa_d     = v1_q[i];
                opb_d     = v2_q[i];
            end
        end

        case (mst_q)
            MUL_IDLE: begin
                if (start_go) begin
                    mst_d  = MUL_BUSY;
                    cnt_d  = CNT_W'(MUL_CYCLES - 1);
                    midx_d = rdy_idx;
                end
            end
            MUL_BUSY: begin
                if (cnt_q == '0) begin
                    mst_d      = MUL_DONE;
                    res_d.tag  = {UNIT_ID, midx_q};
                    res_d.data = product;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MUL_DONE: begin
                if (mul_win) begin
                    mst_d = MUL_IDLE;
                    res_d = '0;
                end
            end
            default: mst_d = MUL_IDLE;
        endcase

        if (div_win) begin
            cdb_vld_d = 1'b1;
            cdb_pay_d = bus.div_in;
        end else if (mul_win) begin
            cdb_vld_d = 1'b1;
            cdb_pay_d = res_q;
        end else if (alu_win) begin
            cdb_vld_d = 1'b1;
            cdb_pay_d = bus.alu_in;
        end else if (ls_win) begin
            cdb_vld_d = 1'b1;
            cdb_pay_d = bus.ls_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            disp_q <= '0;
            for (int i = 0; i < int'(NUM_RS); i++) begin
                q1_q[i] <= '0;
                q2_q[i] <= '0;
                v1_q[i] <= '0;
                v2_q[i] <= '0;
            end
            mst_q     <= MUL_IDLE;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            midx_q    <= '0;
            res_q     <= '0;
            cdb_vld_q <= 1'b0;
            cdb_pay_q <= '0;
        end else begin
            busy_q    <= busy_d;
            disp_q    <= disp_d;
            q1_q      <= q1_d;
            q2_q      <= q2_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            mst_q     <= mst_d;
            cnt_q     <= cnt_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            midx_q    <= midx_d;
            res_q     <= res_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_pay_q <= cdb_pay_d;
        end
    end

    assign bus.issue_tag   = {UNIT_ID, free_idx};
    assign bus.all_busy    = !free_found;
    assign bus.cdb_request = mul_req;
    assign bus.cdb_out     = res_q;
    assign bus.cdb         = {cdb_vld_q, cdb_pay_q};

    // Grants mark the requester whose payload is being latched onto the CDB at the coming edge.
    assign bus.div_grant   = rst && div_win;
    assign bus.alu_grant   = rst && alu_win;
    assign bus.ls_grant    = rst && ls_win;
endmodule

// File: tb/tb_unit_mul_cdb.sv
// Directed bench for unit_mul_cdb: arbiter and multiply vector tables plus
// hand-written sequences for issue ordering, contention, same-edge capture and reset.
module tb_unit_mul_cdb;
    localparam int unsigned MUL_CYCLES = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    unit_mul_cdb_if bus();

    unit_mul_cdb #(
        .NUM_RS     (3),
        .MUL_CYCLES (MUL_CYCLES),
        .UNIT_ID    (5'b01000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
    } mul_vec_t;

    typedef struct {
        logic        div;
        logic        alu;
        logic        ls;
        logic [40:0] cdb;
        logic [2:0]  gnt;
    } arb_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_op(input logic [7:0] q1, input logic [31:0] v1,
                            input logic [7:0] q2, input logic [31:0] v2);
        bus.issue = 1'b1;
        bus.q1_in = q1;
        bus.v1_in = v1;
        bus.q2_in = q2;
        bus.v2_in = v2;
        step();
        bus.issue = 1'b0;
    endtask

    task automatic expect_bcast(input string name, input logic [7:0] tag, input logic [31:0] data);
        int n;
        n = 0;
        step();
        while (!bus.cdb[40] && n < 40) begin
            step();
            n++;
        end
        chk(name, 64'(bus.cdb), 64'({1'b1, tag, data}));
    endtask

    initial begin
        mul_vec_t mv [6];
        arb_vec_t av [7];
        int       n;
        logic     bad;

        mv[0] = '{32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFE};
        mv[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0001};
        mv[2] = '{32'h8000_0000, 32'd2,          32'h0000_0000};
        mv[3] = '{32'h0001_0000, 32'd3,          32'h0003_0000};
        mv[4] = '{32'h0000_0000, 32'hDEAD_BEEF,  32'h0000_0000};
        mv[5] = '{32'h0000_1234, 32'h0000_0010,  32'h0001_2340};

        av[0] = '{1'b0, 1'b1, 1'b0, {1'b1, 8'h08, 32'd7},           3'b010};
        av[1] = '{1'b0, 1'b0, 1'b0, 41'd0,                          3'b000};
        av[2] = '{1'b0, 1'b0, 1'b1, {1'b1, 8'h18, 32'h1234_5678},   3'b001};
        av[3] = '{1'b0, 1'b1, 1'b1, {1'b1, 8'h08, 32'd7},           3'b010};
        av[4] = '{1'b1, 1'b1, 1'b1, {1'b1, 8'h10, 32'h0000_ABCD},   3'b100};
        av[5] = '{1'b1, 1'b0, 1'b1, {1'b1, 8'h10, 32'h0000_ABCD},   3'b100};
        av[6] = '{1'b0, 1'b0, 1'b0, 41'd0,                          3'b000};

        rst         = 1'b1;
        bus.issue   = 1'b0;
        bus.q1_in   = '0;
        bus.q2_in   = '0;
        bus.v1_in   = '0;
        bus.v2_in   = '0;
        bus.alu_req = 1'b0;
        bus.div_req = 1'b0;
        bus.ls_req  = 1'b0;
        bus.alu_in  = {8'h08, 32'd7};
        bus.div_in  = {8'h10, 32'h0000_ABCD};
        bus.ls_in   = {8'h18, 32'h1234_5678};

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cdb",      64'(bus.cdb), 64'd0);
        chk("rst_cdb_req",  64'(bus.cdb_request), 64'd0);
        chk("rst_cdb_out",  64'(bus.cdb_out), 64'd0);
        chk("rst_grants",   64'({bus.div_grant, bus.alu_grant, bus.ls_grant}), 64'd0);
        chk("rst_all_busy", 64'(bus.all_busy), 64'd0);
        chk("rst_tag",      64'(bus.issue_tag), 64'h40);
        rst = 1'b1;
        step();

        // External arbitration with the multiplier idle
        for (int k = 0; k < 7; k++) begin
            bus.div_req = av[k].div;
            bus.alu_req = av[k].alu;
            bus.ls_req  = av[k].ls;
            #1;
            chk($sformatf("arb%0d_grant", k),
                64'({bus.div_grant, bus.alu_grant, bus.ls_grant}), 64'(av[k].gnt));
            step();
            bus.div_req = 1'b0;
            bus.alu_req = 1'b0;
            bus.ls_req  = 1'b0;
            chk($sformatf("arb%0d_cdb", k), 64'(bus.cdb), 64'(av[k].cdb));
        end

        // Three dependent issues, an ignored fourth, then reuse of the freed station
        chk("t1_tag0", 64'(bus.issue_tag), 64'h40);
        issue_op(8'h41, 32'd0, 8'h00, 32'd2);
        chk("t1_tag1", 64'(bus.issue_tag), 64'h41);
        issue_op(8'h00, 32'd2, 8'h00, 32'd3);
        chk("t1_tag2", 64'(bus.issue_tag), 64'h42);
        chk("t1_not_full", 64'(bus.all_busy), 64'd0);
        issue_op(8'h00, 32'd4, 8'h00, 32'd5);
        chk("t1_all_busy", 64'(bus.all_busy), 64'd1);
        issue_op(8'h00, 32'd9, 8'h00, 32'd9);
        chk("t2_still_busy", 64'(bus.all_busy), 64'd1);
        expect_bcast("t1_bcast_41", 8'h41, 32'd6);
        step();
        chk("t2_freed", 64'(bus.all_busy), 64'd0);
        chk("t2_tag",   64'(bus.issue_tag), 64'h41);
        issue_op(8'h00, 32'd7, 8'h00, 32'd3);
        expect_bcast("t1_bcast_42", 8'h42, 32'd20);
        expect_bcast("t1_bcast_40", 8'h40, 32'd12);
        expect_bcast("t2_bcast_41", 8'h41, 32'd21);
        step();

        // div and mul contend for the same edge
        chk("t3_tag", 64'(bus.issue_tag), 64'h40);
        issue_op(8'h00, 32'd3, 8'h00, 32'd4);
        n = 0;
        while (!bus.cdb_request && n < 20) begin
            step();
            n++;
        end
        chk("t3_req_up", 64'(bus.cdb_request), 64'd1);
        bus.div_req = 1'b1;
        bus.div_in  = {8'h10, 32'h0000_ABCD};
        #1;
        chk("t3_div_gnt", 64'({bus.div_grant, bus.alu_grant, bus.ls_grant}), 64'h4);
        step();
        bus.div_req = 1'b0;
        chk("t3_cdb_div",  64'(bus.cdb), 64'({1'b1, 8'h10, 32'h0000_ABCD}));
        chk("t3_req_held", 64'(bus.cdb_request), 64'd1);
        chk("t3_cdb_out",  64'(bus.cdb_out), 64'({8'h40, 32'd12}));
        step();
        chk("t3_cdb_mul",  64'(bus.cdb), 64'({1'b1, 8'h40, 32'd12}));
        chk("t3_req_clr",  64'(bus.cdb_request), 64'd0);
        step();

        // Operand tag broadcast while the issue is being sampled
        bus.alu_req = 1'b1;
        bus.alu_in  = {8'h08, 32'd9};
        step();
        bus.alu_req = 1'b0;
        chk("t5_cdb_alu", 64'(bus.cdb), 64'({1'b1, 8'h08, 32'd9}));
        issue_op(8'h08, 32'd100, 8'h00, 32'd5);
        expect_bcast("t5_bcast", 8'h40, 32'd45);
        step();

        // Issue on the same edge that latches the producer onto the CDB
        bus.alu_req = 1'b1;
        bus.alu_in  = {8'h08, 32'd11};
        issue_op(8'h08, 32'd100, 8'h00, 32'd3);
        bus.alu_req = 1'b0;
        expect_bcast("t5b_bcast", 8'h40, 32'd33);
        step();

        // Multiply vectors with exact completion latency
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("mul%0d_tag", k), 64'(bus.issue_tag), 64'h40);
            issue_op(8'h00, mv[k].a, 8'h00, mv[k].b);
            repeat (MUL_CYCLES) step();
            chk($sformatf("mul%0d_early", k), 64'(bus.cdb_request), 64'd0);
            step();
            chk($sformatf("mul%0d_req", k), 64'(bus.cdb_request), 64'd1);
            chk($sformatf("mul%0d_out", k), 64'(bus.cdb_out), 64'({8'h40, mv[k].prod}));
            step();
            chk($sformatf("mul%0d_cdb", k), 64'(bus.cdb), 64'({1'b1, 8'h40, mv[k].prod}));
            step();
        end

        // Reset in the middle of a multiply
        issue_op(8'h00, 32'hFFFF_FFFF, 8'h00, 32'd2);
        bus.alu_req = 1'b1;
        bus.alu_in  = {8'h08, 32'd7};
        step();
        bus.alu_req = 1'b0;
        chk("t6_pre_rst_cdb", 64'(bus.cdb), 64'({1'b1, 8'h08, 32'd7}));
        step();
        rst = 1'b0;
        #1;
        chk("t6_rst_cdb",      64'(bus.cdb), 64'd0);
        chk("t6_rst_req",      64'(bus.cdb_request), 64'd0);
        chk("t6_rst_out",      64'(bus.cdb_out), 64'd0);
        chk("t6_rst_all_busy", 64'(bus.all_busy), 64'd0);
        chk("t6_rst_tag",      64'(bus.issue_tag), 64'h40);
        step();
        step();
        rst = 1'b1;
        bad = 1'b0;
        repeat (12) begin
            step();
            if (bus.cdb[40] || bus.cdb_request) bad = 1'b1;
        end
        chk("t6_no_stale", 64'(bad), 64'd0);
        issue_op(8'h00, 32'd6, 8'h00, 32'd7);
        expect_bcast("t6_after_rst", 8'h40, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
